abft_acc_sequencer: RTL and testbench

Controller for the four-lane (w/x/y/z) checksum accumulator in the ABFT datapath. It accepts a job of N tiles and streams arraySize consecutive valid beats per tile from the upstream checksum source into the accumulator. After each tile it waits for the accumulator result and compares the four accumulated sums against reference checksums, with a tolerance. It reports per-lane mismatches, a saturating faulty-tile count and timeouts, and owns the accumulator's valid/interrupt controls, including recovery from mid-tile bubbles and host abort.

---
 rtl/abft_acc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_abft_acc_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abft_acc_sequencer.sv
// abft_acc_sequencer: feeds arraySize beats per tile into the w/x/y/z checksum
// accumulator, waits for its result and checks all four lanes against reference
// checksums within a tolerance. It also handles mid-tile bubbles, drain timeouts
// and host aborts.
module abft_acc_sequencer #(
  parameter int unsigned arraySize    = 4,
  parameter int unsigned addressWidth = 2,
  parameter int unsigned zBits        = 28,
  parameter int unsigned tileBits     = 16,
  parameter int unsigned countBits    = 16,
  parameter int unsigned tolerance    = 0,
  parameter int unsigned drainTimeout = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [tileBits-1:0]  num_tiles,
  input  logic                 abort,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 acc_valid,
  output logic                 acc_interrupt,
  input  logic                 acc_valid_out,
  input  logic [zBits-1:0]     w_acc,
  input  logic [zBits-1:0]     x_acc,
  input  logic [zBits-1:0]     y_acc,
  input  logic [zBits-1:0]     z_acc,
  input  logic [zBits-1:0]     w_ref,
  input  logic [zBits-1:0]     x_ref,
  input  logic [zBits-1:0]     y_ref,
  input  logic [zBits-1:0]     z_ref,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 tile_retry,
  output logic [tileBits-1:0]  tile_idx,
  output logic [3:0]           err_lanes,
  output logic [countBits-1:0] err_count,
  output logic                 timeout
);

  localparam int unsigned TimerBits = $clog2(drainTimeout + 1);
  localparam int unsigned DiffBits  = zBits + 1;

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, CHECK, DONE} state_t;

  state_t                    state;
  logic [addressWidth-1:0]   row;
  logic [TimerBits-1:0]      timer;
  logic [tileBits-1:0]       num_tiles_q;
  logic [3:0][zBits-1:0]     acc_q;
  logic [3:0][zBits-1:0]     ref_q;
  logic [3:0][DiffBits-1:0]  diff;
  logic [3:0]                mism;
  logic                      bubble;
  logic                      last_beat;
  logic                      last_tile;
  logic                      timer_end;

  // Handshake and status outputs decoded straight from the state register
  assign data_ready    = (state == FEED);
  assign acc_valid     = data_valid & data_ready;
  assign bubble        = data_ready & ~data_valid & (row != '0);
  assign tile_retry    = bubble;
  assign acc_interrupt = bubble | ((state != IDLE) & abort);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  assign last_beat = (row == addressWidth'(arraySize - 1));
  assign last_tile = (tile_idx == num_tiles_q - tileBits'(1));
  assign timer_end = (timer == TimerBits'(drainTimeout - 1));

  // Per-lane absolute difference, one bit wider than the operands so it never wraps
  always_comb begin
    diff = '0;
    mism = '0;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[i] >= ref_q[i]) begin
        diff[i] = {1'b0, acc_q[i]} - {1'b0, ref_q[i]};
      end else begin
        diff[i] = {1'b0, ref_q[i]} - {1'b0, acc_q[i]};
      end
      mism[i] = (diff[i] > DiffBits'(tolerance));
    end
  end

  // Sequencer FSM with all registered state, flags and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      timer       <= '0;
      num_tiles_q <= '0;
      tile_idx    <= '0;
      err_lanes   <= '0;
      err_count   <= '0;
      timeout     <= 1'b0;
      aborted     <= 1'b0;
      acc_q       <= '0;
      ref_q       <= '0;
    end else begin
      aborted <= 1'b0;
      if ((state != IDLE) && abort) begin
        state   <= IDLE;
        row     <= '0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              num_tiles_q <= num_tiles;
              err_lanes   <= '0;
              err_count   <= '0;
              timeout     <= 1'b0;
              tile_idx    <= '0;
              row         <= '0;
              state       <= (num_tiles == '0) ? DONE : FEED;
            end
          end
          FEED: begin
            if (data_valid) begin
              if (last_beat) begin
                row   <= '0;
                timer <= '0;
                state <= DRAIN;
              end else begin
                row <= row + addressWidth'(1);
              end
            end else begin
              row <= '0;
            end
          end
          DRAIN: begin
            if (acc_valid_out) begin
              acc_q <= {z_acc, y_acc, x_acc, w_acc};
              ref_q <= {z_ref, y_ref, x_ref, w_ref};
              state <= CHECK;
            end else if (timer_end) begin
              timeout <= 1'b1;
              state   <= DONE;
            end else begin
              timer <= timer + TimerBits'(1);
            end
          end
          CHECK: begin
            err_lanes <= err_lanes | mism;
            if ((mism != '0) && (err_count != '1)) begin
              err_count <= err_count + countBits'(1);
            end
            if (last_tile) begin
              state <= DONE;
            end else begin
              tile_idx <= tile_idx + tileBits'(1);
              row      <= '0;
              state    <= FEED;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_abft_acc_sequencer.sv
// Directed bench for abft_acc_sequencer: a tolerance-2 instance and a
// tolerance-0 / 2-bit-counter instance share one stimulus stream.
module tb_abft_acc_sequencer;

  localparam int unsigned ZB = 28;
  localparam int unsigned TB = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, data_valid, acc_valid_out;
  logic [TB-1:0] num_tiles;
  logic [ZB-1:0] w_acc, x_acc, y_acc, z_acc, w_ref, x_ref, y_ref, z_ref;

  logic          data_ready, acc_valid, acc_interrupt, busy, done, aborted, tile_retry, timeout;
  logic [TB-1:0] tile_idx;
  logic [3:0]    err_lanes;
  logic [15:0]   err_count;

  logic          s_data_ready, s_acc_valid, s_acc_interrupt, s_busy, s_done, s_aborted, s_tile_retry, s_timeout;
  logic [TB-1:0] s_tile_idx;
  logic [3:0]    s_err_lanes;
  logic [1:0]    s_err_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int beats    = 0;

  abft_acc_sequencer #(.tolerance(2)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .abort(abort),
    .data_valid(data_valid), .data_ready(data_ready), .acc_valid(acc_valid),
    .acc_interrupt(acc_interrupt), .acc_valid_out(acc_valid_out),
    .w_acc(w_acc), .x_acc(x_acc), .y_acc(y_acc), .z_acc(z_acc),
    .w_ref(w_ref), .x_ref(x_ref), .y_ref(y_ref), .z_ref(z_ref),
    .busy(busy), .done(done), .aborted(aborted), .tile_retry(tile_retry),
    .tile_idx(tile_idx), .err_lanes(err_lanes), .err_count(err_count), .timeout(timeout)
  );

  abft_acc_sequencer #(.countBits(2), .tolerance(0)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .abort(abort),
    .data_valid(data_valid), .data_ready(s_data_ready), .acc_valid(s_acc_valid),
    .acc_interrupt(s_acc_interrupt), .acc_valid_out(acc_valid_out),
    .w_acc(w_acc), .x_acc(x_acc), .y_acc(y_acc), .z_acc(z_acc),
    .w_ref(w_ref), .x_ref(x_ref), .y_ref(y_ref), .z_ref(z_ref),
    .busy(s_busy), .done(s_done), .aborted(s_aborted), .tile_retry(s_tile_retry),
    .tile_idx(s_tile_idx), .err_lanes(s_err_lanes), .err_count(s_err_count), .timeout(s_timeout)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_vals(input logic [ZB-1:0] wa, input logic [ZB-1:0] wr,
                          input logic [ZB-1:0] xa, input logic [ZB-1:0] xr,
                          input logic [ZB-1:0] ya, input logic [ZB-1:0] yr,
                          input logic [ZB-1:0] za, input logic [ZB-1:0] zr);
    w_acc = wa; w_ref = wr; x_acc = xa; x_ref = xr;
    y_acc = ya; y_ref = yr; z_acc = za; z_ref = zr;
  endtask

  task automatic start_job(input int n);
    start     = 1'b1;
    num_tiles = TB'(n);
    t0        = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic feed_beats(input int n);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      #1;
      if (acc_valid) beats++;
      tick();
    end
    data_valid = 1'b0;
  endtask

  // Called in the first DRAIN cycle; raises acc_valid_out in DRAIN cycle lat, returns in CHECK
  task automatic pulse_result(input int lat);
    data_valid = 1'b0;
    repeat (lat - 1) tick();
    acc_valid_out = 1'b1;
    tick();
    acc_valid_out = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_tiles = '0; abort = 1'b0;
    data_valid = 1'b0; acc_valid_out = 1'b0;
    set_vals(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data_ready", 32'(data_ready), 0);
    chk("rst_acc_valid", 32'(acc_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_err_lanes", 32'(err_lanes), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_tile_idx", 32'(tile_idx), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
    tick();

    // Two clean tiles, result 6 cycles into DRAIN
    set_vals(50, 50, 50, 50, 50, 50, 50, 50);
    beats = 0;
    start_job(2); #1;
    chk("a_ready_after_start", 32'(data_ready), 1);
    feed_beats(4);
    pulse_result(6); #1;
    chk("a_no_done_in_check", 32'(done), 0);
    chk("a_busy_in_check", 32'(busy), 1);
    tick();
    feed_beats(4);
    pulse_result(6); #1;
    chk("a_tile_idx", 32'(tile_idx), 1);
    tick(); #1;
    chk("a_done", 32'(done), 1);
    chk("a_done_cycle", 32'(cyc - t0), 23);
    chk("a_beats", 32'(beats), 8);
    chk("a_err_lanes", 32'(err_lanes), 0);
    chk("a_err_count", 32'(err_count), 0);
    tick(); #1;
    chk("a_idle_busy", 32'(busy), 0);
    chk("a_done_pulse", 32'(done), 0);

    // x lane off by 3 on tile 0 exceeds tolerance 2
    set_vals(7, 7, 100, 103, 7, 7, 7, 7);
    start_job(2);
    feed_beats(4);
    pulse_result(3); #1;
    chk("b_lanes_in_check", 32'(err_lanes), 0);
    tick(); #1;
    chk("b_lanes_after_check", 32'(err_lanes), 4'b0010);
    chk("b_count_after_check", 32'(err_count), 1);
    set_vals(9, 9, 9, 9, 9, 9, 9, 9);
    feed_beats(4);
    pulse_result(2);
    tick(); #1;
    chk("b_done", 32'(done), 1);
    chk("b_lanes_final", 32'(err_lanes), 4'b0010);
    chk("b_count_final", 32'(err_count), 1);
    chk("b_sat_count", 32'(s_err_count), 1);
    tick();

    // Differences of exactly 2 pass at tolerance 2; z lane would wrap to 2 if computed at zBits
    set_vals(5, 3, 100, 102, 7, 7, 1, 28'hFFFFFFF);
    start_job(1);
    feed_beats(4);
    pulse_result(1);
    tick(); #1;
    chk("b2_lanes", 32'(err_lanes), 4'b1000);
    chk("b2_count", 32'(err_count), 1);
    chk("b2_sat_lanes", 32'(s_err_lanes), 4'b1011);
    tick();

    // Bubbles: idle at row 0 is legal, a gap after beat 2 restarts the tile
    set_vals(11, 11, 11, 11, 11, 11, 11, 11);
    start_job(1);
    data_valid = 1'b0; #1;
    chk("c_row0_interrupt", 32'(acc_interrupt), 0);
    chk("c_row0_retry", 32'(tile_retry), 0);
    tick(); #1;
    chk("c_row0_still_feed", 32'(data_ready), 1);
    feed_beats(2);
    data_valid = 1'b0; #1;
    chk("c_bubble_interrupt", 32'(acc_interrupt), 1);
    chk("c_bubble_retry", 32'(tile_retry), 1);
    chk("c_bubble_acc_valid", 32'(acc_valid), 0);
    tick();
    beats = 0;
    feed_beats(3); #1;
    chk("c_three_beats_still_feed", 32'(data_ready), 1);
    feed_beats(1); #1;
    chk("c_drain_after_four", 32'(data_ready), 0);
    chk("c_beats", 32'(beats), 4);
    pulse_result(2);
    tick(); #1;
    chk("c_done", 32'(done), 1);
    tick();

    // Drain timeout with no accumulator result
    set_vals(0, 0, 0, 0, 0, 0, 0, 0);
    start_job(1);
    feed_beats(4);
    repeat (15) tick();
    #1;
    chk("d_no_timeout_yet", 32'(timeout), 0);
    chk("d_busy_in_drain", 32'(busy), 1);
    tick(); #1;
    chk("d_timeout", 32'(timeout), 1);
    chk("d_done", 32'(done), 1);
    tick(); #1;
    chk("d_busy_dropped", 32'(busy), 0);
    chk("d_timeout_sticky", 32'(timeout), 1);

    // Abort in DRAIN of tile 1 of 3, flags hold
    set_vals(20, 20, 20, 20, 20, 30, 20, 20);
    start_job(3); #1;
    chk("e_timeout_cleared", 32'(timeout), 0);
    feed_beats(4);
    pulse_result(2);
    tick(); #1;
    chk("e_lanes_tile0", 32'(err_lanes), 4'b0100);
    set_vals(20, 20, 20, 20, 20, 20, 20, 20);
    feed_beats(4);
    tick();
    abort = 1'b1; #1;
    chk("e_abort_interrupt", 32'(acc_interrupt), 1);
    tick();
    abort = 1'b0; #1;
    chk("e_aborted", 32'(aborted), 1);
    chk("e_abort_busy", 32'(busy), 0);
    chk("e_abort_no_done", 32'(done), 0);
    chk("e_hold_lanes", 32'(err_lanes), 4'b0100);
    chk("e_hold_count", 32'(err_count), 1);
    tick(); #1;
    chk("e_aborted_one_cycle", 32'(aborted), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0; #1;
    chk("e_idle_abort_ignored", 32'(aborted), 0);
    // Empty job with abort alongside start: start wins, flags cleared
    data_valid = 1'b1;
    abort = 1'b1;
    start_job(0);
    abort = 1'b0; #1;
    chk("e_zero_done", 32'(done), 1);
    chk("e_zero_done_cycle", 32'(cyc - t0), 1);
    chk("e_zero_not_aborted", 32'(aborted), 0);
    chk("e_zero_no_beat", 32'(acc_valid), 0);
    chk("e_cleared_lanes", 32'(err_lanes), 0);
    chk("e_cleared_count", 32'(err_count), 0);
    data_valid = 1'b0;
    tick(); #1;
    chk("e_zero_idle", 32'(busy), 0);

    // Five faulty tiles: 16-bit counter reaches 5, 2-bit counter saturates at 3
    set_vals(10, 20, 5, 5, 5, 5, 5, 5);
    start_job(5);
    for (int i = 0; i < 5; i++) begin
      feed_beats(4);
      pulse_result(1);
      tick();
    end
    #1;
    chk("f_done", 32'(done), 1);
    chk("f_count", 32'(err_count), 5);
    chk("f_sat_count", 32'(s_err_count), 3);
    chk("f_sat_lanes", 32'(s_err_lanes), 4'b0001);
    tick();

    // Reset mid-job
    start_job(2);
    feed_beats(4);
    pulse_result(1);
    tick(); #1;
    chk("g_count_before_rst", 32'(err_count), 1);
    feed_beats(2);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("g_busy", 32'(busy), 0);
    chk("g_data_ready", 32'(data_ready), 0);
    chk("g_count", 32'(err_count), 0);
    chk("g_lanes", 32'(err_lanes), 0);
    chk("g_tile_idx", 32'(tile_idx), 0);
    chk("g_done", 32'(done), 0);
    chk("g_aborted", 32'(aborted), 0);
    tick(); #1;
    chk("g_no_late_done", 32'(done), 0);
    chk("g_no_late_aborted", 32'(aborted), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
